// File: rtl/demux_8_buf.sv
// demux_8_buf: eight-slot output demultiplexer with one registered word per slot.
//
// A producer offers a word (in) for a destination slot (addr). The word is accepted
// when the slot is empty, or when that slot's consumer takes its current word in the
// same cycle. Each consumer i reads out<i>/valid[i] and pulses ack[i] to take the word.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset, clears all slots
//   in       - write data word
//   addr     - destination slot index 0..7
//   in_valid - producer offers in/addr this cycle
//   in_ready - word offered this cycle is accepted (combinational)
//   stall    - blocks all writes; acks are still serviced
//   out0..7  - slot data registers (0 when the slot is empty)
//   valid    - bit i set while slot i holds an unconsumed word
//   ack      - bit i: consumer of slot i takes its word this cycle
//   count    - registered number of occupied slots, 0..8
module demux_8_buf #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] in,
    input  logic [2:0]       addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic [width-1:0] out0,
    output logic [width-1:0] out1,
    output logic [width-1:0] out2,
    output logic [width-1:0] out3,
    output logic [width-1:0] out4,
    output logic [width-1:0] out5,
    output logic [width-1:0] out6,
    output logic [width-1:0] out7,
    output logic [7:0]       valid,
    input  logic [7:0]       ack,
    output logic [3:0]       count
);

    logic [width-1:0] data_q [8];
    logic [width-1:0] data_d [8];
    logic [7:0]       valid_q;
    logic [7:0]       valid_d;
    logic [3:0]       count_q;
    logic [3:0]       count_d;
    logic             accept;

    // A full slot can take a new word only in the cycle its consumer acks it.
    assign in_ready = !stall && (!valid_q[addr] || ack[addr]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        count_d = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            data_d[i] = data_q[i];
        end

        // Drain acked slots first; an accept to the same slot then overrides the
        // clear so a same-cycle refill produces no bubble.
        for (int unsigned i = 0; i < 8; i++) begin
            if (ack[i] && valid_q[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end
        end

        if (accept) begin
            valid_d[addr] = 1'b1;
            data_d[addr]  = in;
        end

        for (int unsigned i = 0; i < 8; i++) begin
            count_d = count_d + {3'b000, valid_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign valid = valid_q;
    assign count = count_q;
    assign out0  = data_q[0];
    assign out1  = data_q[1];
    assign out2  = data_q[2];
    assign out3  = data_q[3];
    assign out4  = data_q[4];
    assign out5  = data_q[5];
    assign out6  = data_q[6];
    assign out7  = data_q[7];

endmodule

// File: tb/tb_demux_8_buf.sv
// Self-checking bench for demux_8_buf: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a slot-occupancy model.
module tb_demux_8_buf;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  din = '0;
    logic [2:0]    addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          stall = 1'b0;
    logic [W-1:0]  o [8];
    logic [7:0]    valid;
    logic [7:0]    ack = '0;
    logic [3:0]    count;

    int total = 0;
    int bad   = 0;

    // Model: what each slot currently holds, and whether it is occupied.
    logic [W-1:0]  m_data [8];
    bit            m_full [8];

    demux_8_buf #(.width(W)) dut (
        .clk(clk), .rst(rst), .in(din), .addr(addr), .in_valid(in_valid),
        .in_ready(in_ready), .stall(stall),
        .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]),
        .out4(o[4]), .out5(o[5]), .out6(o[6]), .out7(o[7]),
        .valid(valid), .ack(ack), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_data[i] = '0;
            m_full[i] = 0;
        end
    endfunction

    function automatic bit model_can_take(input int a);
        return !stall && (!m_full[a] || ack[a] == 1'b1);
    endfunction

    function automatic logic [7:0] model_valid();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_full[i];
        return v;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_full[i]) n++;
        return n;
    endfunction

    task automatic check_all();
        chk("valid", valid, model_valid());
        chk("count", count, model_count());
        for (int i = 0; i < 8; i++) chk($sformatf("out%0d", i), o[i], m_data[i]);
    endtask

    // Called with inputs already applied, just after a rising edge.
    task automatic step();
        bit take;
        int a;
        #1;
        a = int'(addr);
        chk("in_ready", in_ready, model_can_take(a));
        take = in_valid && model_can_take(a) && !rst;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (ack[i] && m_full[i]) begin
                    m_full[i] = 0;
                    m_data[i] = '0;
                end
            end
            if (take) begin
                m_full[a] = 1;
                m_data[a] = din;
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input int a, input logic [W-1:0] d,
                         input bit st, input logic [7:0] ak);
        in_valid = v;
        addr     = 3'(a);
        din      = d;
        stall    = st;
        ack      = ak;
        step();
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 8'h00);
    endtask

    initial begin
        model_clear();
        rst = 1'b1;
        #1;
        chk("reset_valid", valid, 8'h00);
        chk("reset_count", count, 4'd0);
        chk("reset_out0", o[0], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        // Fill all slots.
        for (int i = 0; i < 8; i++) drive(1, i, 32'hA0 + i, 0, 8'h00);
        chk("fill_valid", valid, 8'hFF);
        chk("fill_count", count, 4'd8);
        chk("fill_out5", o[5], 32'hA5);
        in_valid = 1'b1;
        ack = '0;
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            #1;
            chk("full_in_ready", in_ready, 1'b0);
        end
        drive(0, 0, '0, 0, 8'hFF);
        chk("drain_all_count", count, 4'd0);

        // Backpressure on a held slot.
        drive(1, 3, 32'h1111, 0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            drive(1, 3, 32'h2222, 0, 8'h00);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out3", o[3], 32'h1111);
        end

        // Same-cycle refill.
        drive(1, 5, 32'h55, 0, 8'h00);
        chk("refill_pre_count", count, 4'd2);
        drive(1, 5, 32'h66, 0, 8'h20);
        chk("refill_valid5", valid[5], 1'b1);
        chk("refill_out5", o[5], 32'h66);
        chk("refill_count", count, 4'd2);
        drive(0, 0, '0, 0, 8'hFF);

        // Drain two slots together, then ack an empty slot.
        drive(1, 0, 32'h10, 0, 8'h00);
        drive(1, 2, 32'h12, 0, 8'h00);
        drive(0, 0, '0, 0, 8'h05);
        chk("drain_valid", valid, 8'h00);
        chk("drain_out2", o[2], 32'h0);
        chk("drain_count", count, 4'd0);
        drive(0, 0, '0, 0, 8'h80);
        chk("ack_empty_valid", valid, 8'h00);

        // Stall blocks writes while acks still drain.
        drive(1, 4, 32'h44, 0, 8'h00);
        drive(1, 6, 32'h46, 0, 8'h00);
        drive(1, 1, 32'h99, 1, 8'h10);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_valid", valid, 8'h40);
        chk("stall_count", count, 4'd1);
        drive(0, 0, '0, 0, 8'hFF);

        // Asynchronous reset mid-cycle with six slots held.
        for (int i = 0; i < 6; i++) drive(1, i, 32'hC0 + i, 0, 8'h00);
        chk("pre_rst_count", count, 4'd6);
        in_valid = 1'b1;
        addr = 3'd2;
        din = 32'hDEAD;
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", valid, 8'h00);
        chk("async_count", count, 4'd0);
        chk("async_out0", o[0], 32'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_no_accept", valid, 8'h00);
        rst = 1'b0;
        drive(1, 2, 32'h22, 0, 8'h00);
        chk("post_rst_count", count, 4'd1);
        chk("post_rst_out2", o[2], 32'h22);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] ak;
            ak = 8'($urandom) & 8'($urandom) & 8'($urandom);
            drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), W'($urandom),
                  bit'($urandom_range(0, 7) == 0), ak);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
